mprj_power_seq: RTL and testbench

MPRJ_POWER_SEQ -- requirements
Module: mprj_power_seq

---
 rtl/mprj_power_seq.sv | 143 ++++++++++++++
 tb/tb_mprj_power_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mprj_power_seq.sv
// User-project power sequencer for the two Caravel user domains.
// Each domain's level-shifted presence flag is synchronized into caravel_clk,
// debounced, and then held for a fixed delay before the isolation cells are
// released. Loss of a good domain drops isolation at once and raises a
// one-cycle pwr_lost pulse. Dropping seq_enable is an orderly shutdown: the
// domain goes to OFF without a pwr_lost pulse.
module mprj_power_seq #(
    parameter int DEBOUNCE_CYCLES = 16,  // consecutive synced-high samples, 2..255
    parameter int RELEASE_DELAY   = 8    // power-good to isolation release, 1..255
) (
    input  logic caravel_clk,
    input  logic caravel_rstn,
    input  logic seq_enable,
    input  logic mprj_vdd_logic1,
    input  logic mprj2_vdd_logic1,
    output logic mprj_pwr_good,
    output logic mprj2_pwr_good,
    output logic mprj_iso_rel,
    output logic mprj2_iso_rel,
    output logic mprj_pwr_lost,
    output logic mprj2_pwr_lost
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DEBOUNCE,
        ST_RELEASE,
        ST_ON
    } state_t;

    // Terminal counts. The counter only ever climbs to one of these values,
    // so it cannot wrap.
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] REL_LAST = 8'(RELEASE_DELAY - 1);

    logic [1:0] vdd;
    assign vdd = {mprj2_vdd_logic1, mprj_vdd_logic1};

    // The two domains share no state, so events in both are handled in the
    // same cycle.
    for (genvar d = 0; d < 2; d++) begin : g_dom
        logic       sync_q;
        logic       sync_d;
        state_t     state;
        logic [7:0] cnt;
        logic       pwr_good;
        logic       iso_rel;
        logic       pwr_lost;

        // Two-flop synchronizer for the asynchronous presence flag.
        always_ff @(posedge caravel_clk or negedge caravel_rstn) begin
            if (!caravel_rstn) begin
                sync_q <= 1'b0;
                sync_d <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments let sync_d take the old sync_q,
                // giving two real flop stages; blocking would collapse them.
                sync_q <= vdd[d];
                sync_d <= sync_q;
            end
        end

        // Sequencing FSM with registered pwr_good / iso_rel / pwr_lost.
        always_ff @(posedge caravel_clk or negedge caravel_rstn) begin
            if (!caravel_rstn) begin
                state    <= ST_OFF;
                cnt      <= 8'd0;
                pwr_good <= 1'b0;
                iso_rel  <= 1'b0;
                pwr_lost <= 1'b0;
            end else begin
                pwr_lost <= 1'b0;
                if (!seq_enable) begin
                    // An orderly shutdown wins over any presence event this cycle.
                    state    <= ST_OFF;
                    cnt      <= 8'd0;
                    pwr_good <= 1'b0;
                    iso_rel  <= 1'b0;
                end else begin
                    case (state)
                        ST_OFF: begin
                            if (sync_d) begin
                                state <= ST_DEBOUNCE;
                                cnt   <= 8'd1;
                            end
                        end
                        ST_DEBOUNCE: begin
                            if (!sync_d) begin
                                // A glitch restarts debounce from scratch.
                                state <= ST_OFF;
                                cnt   <= 8'd0;
                            end else if (cnt == DEB_LAST) begin
                                state    <= ST_RELEASE;
                                cnt      <= 8'd0;
                                pwr_good <= 1'b1;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                        ST_RELEASE: begin
                            if (!sync_d) begin
                                state    <= ST_OFF;
                                cnt      <= 8'd0;
                                pwr_good <= 1'b0;
                                iso_rel  <= 1'b0;
                                pwr_lost <= 1'b1;
                            end else if (cnt == REL_LAST) begin
                                state   <= ST_ON;
                                cnt     <= 8'd0;
                                iso_rel <= 1'b1;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                        ST_ON: begin
                            if (!sync_d) begin
                                state    <= ST_OFF;
                                cnt      <= 8'd0;
                                pwr_good <= 1'b0;
                                iso_rel  <= 1'b0;
                                pwr_lost <= 1'b1;
                            end
                        end
                        default: begin
                            state    <= ST_OFF;
                            cnt      <= 8'd0;
                            pwr_good <= 1'b0;
                            iso_rel  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign mprj_pwr_good  = g_dom[0].pwr_good;
    assign mprj_iso_rel   = g_dom[0].iso_rel;
    assign mprj_pwr_lost  = g_dom[0].pwr_lost;
    assign mprj2_pwr_good = g_dom[1].pwr_good;
    assign mprj2_iso_rel  = g_dom[1].iso_rel;
    assign mprj2_pwr_lost = g_dom[1].pwr_lost;

endmodule

// File: tb/tb_mprj_power_seq.sv
// Directed bench for mprj_power_seq with DEBOUNCE_CYCLES=4, RELEASE_DELAY=2.
// Edge numbers count rising caravel_clk edges after reset release; outputs
// are sampled 1 ns after an edge and inputs change at that same point.
module tb_mprj_power_seq;

    logic caravel_clk;
    logic caravel_rstn;
    logic seq_enable;
    logic mprj_vdd_logic1;
    logic mprj2_vdd_logic1;
    logic mprj_pwr_good;
    logic mprj2_pwr_good;
    logic mprj_iso_rel;
    logic mprj2_iso_rel;
    logic mprj_pwr_lost;
    logic mprj2_pwr_lost;

    int tests  = 0;
    int failed = 0;
    int e      = 0;

    // Output bundle: {pg1, iso1, lost1, pg2, iso2, lost2}
    logic [5:0] outs;
    assign outs = {mprj_pwr_good, mprj_iso_rel, mprj_pwr_lost,
                   mprj2_pwr_good, mprj2_iso_rel, mprj2_pwr_lost};

    mprj_power_seq #(
        .DEBOUNCE_CYCLES(4),
        .RELEASE_DELAY  (2)
    ) dut (
        .caravel_clk     (caravel_clk),
        .caravel_rstn    (caravel_rstn),
        .seq_enable      (seq_enable),
        .mprj_vdd_logic1 (mprj_vdd_logic1),
        .mprj2_vdd_logic1(mprj2_vdd_logic1),
        .mprj_pwr_good   (mprj_pwr_good),
        .mprj2_pwr_good  (mprj2_pwr_good),
        .mprj_iso_rel    (mprj_iso_rel),
        .mprj2_iso_rel   (mprj2_iso_rel),
        .mprj_pwr_lost   (mprj_pwr_lost),
        .mprj2_pwr_lost  (mprj2_pwr_lost)
    );

    initial caravel_clk = 1'b0;
    always #5 caravel_clk = ~caravel_clk;

    task automatic check(input string tag, input logic [5:0] exp);
        tests++;
        assert (outs === exp) else begin
            failed++;
            $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, e, outs, exp);
        end
    endtask

    // Advance to 1 ns after the n-th next rising edge.
    task automatic adv(input int n);
        repeat (n) @(posedge caravel_clk);
        e += n;
        #1;
    endtask

    task automatic adv_to(input int target);
        adv(target - e);
    endtask

    initial begin
        caravel_rstn     = 1'b0;
        seq_enable       = 1'b0;
        mprj_vdd_logic1  = 1'b0;
        mprj2_vdd_logic1 = 1'b0;
        #2;
        check("reset_state", 6'b000_000);
        repeat (2) @(posedge caravel_clk);
        #1;
        caravel_rstn = 1'b1;
        e = 0;

        // Domain 1 power-up: pwr_good after edge 6, iso_rel after edge 8.
        seq_enable      = 1'b1;
        mprj_vdd_logic1 = 1'b1;
        adv_to(5);  check("up_e5_idle",        6'b000_000);
        adv_to(6);  check("up_e6_pwr_good",    6'b100_000);
        adv_to(7);  check("up_e7_release",     6'b100_000);
        adv_to(8);  check("up_e8_iso_rel",     6'b110_000);

        // Domain 1 loss: input falls between edges 19 and 20.
        adv_to(19);
        mprj_vdd_logic1 = 1'b0;
        adv_to(21); check("loss_e21_still_on", 6'b110_000);
        adv_to(22); check("loss_e22_lost",     6'b001_000);
        adv_to(23); check("loss_e23_pulse_end",6'b000_000);

        // Glitch: 3 synced highs (edges 26..28), one low (29), then high.
        mprj_vdd_logic1 = 1'b1;
        adv_to(26);
        mprj_vdd_logic1 = 1'b0;
        adv_to(27);
        mprj_vdd_logic1 = 1'b1;
        adv_to(28); check("glitch_e28_no_good",6'b000_000);
        adv_to(29); check("glitch_e29_no_lost",6'b000_000);
        adv_to(32); check("glitch_e32_no_good",6'b000_000);
        adv_to(33); check("glitch_e33_good",   6'b100_000);
        adv_to(35); check("glitch_e35_on",     6'b110_000);

        // Bring domain 2 up while domain 1 stays on.
        mprj2_vdd_logic1 = 1'b1;
        adv_to(40); check("d2_e40_debounce",   6'b110_000);
        adv_to(41); check("d2_e41_good",       6'b110_100);
        adv_to(43); check("d2_e43_both_on",    6'b110_110);

        // Orderly disable: both cleared next edge, no pwr_lost.
        seq_enable = 1'b0;
        adv_to(44); check("dis_e44_cleared",   6'b000_000);
        adv_to(45); check("dis_e45_no_lost",   6'b000_000);

        // Re-enable restarts debounce from OFF in both domains together.
        seq_enable = 1'b1;
        adv_to(48); check("reen_e48_debounce", 6'b000_000);
        adv_to(49); check("reen_e49_good",     6'b100_100);
        adv_to(51); check("reen_e51_on",       6'b110_110);

        // Reset in RELEASE: outputs drop immediately, then full resequence.
        seq_enable = 1'b0;
        adv_to(52);
        seq_enable = 1'b1;
        adv_to(56); check("rst_e56_release",   6'b100_100);
        caravel_rstn = 1'b0;
        #1;         check("rst_async_clear",   6'b000_000);
        adv_to(57); check("rst_held",          6'b000_000);
        adv_to(58);
        caravel_rstn = 1'b1;
        adv_to(63); check("rst2_e5_idle",      6'b000_000);
        adv_to(64); check("rst2_e6_good",      6'b100_100);
        adv_to(65); check("rst2_e7_release",   6'b100_100);
        adv_to(66); check("rst2_e8_on",        6'b110_110);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
